// File: rtl/soduku_board_loader.sv
// rtl/soduku_board_loader.sv - packs 81 streamed BCD digits into the solver board and sequences its reset/done handshake.
module soduku_board_loader #(
   parameter int GRID_SIZE        = 9,
   parameter int CELL_W           = 4,
   parameter int SOLVE_RST_CYCLES = 2,
   parameter int TIMEOUT_CYCLES   = 1000000
) (
   input  logic                                   clk_in,
   input  logic                                   reset_n_in,
   input  logic [CELL_W-1:0]                      digit_in,
   input  logic                                   digit_valid_in,
   output logic                                   digit_ready_out,
   input  logic                                   clear_in,
   output logic [GRID_SIZE*GRID_SIZE*CELL_W-1:0]  board_out,
   output logic                                   solver_reset_out,
   input  logic                                   solver_done_in,
   output logic [6:0]                             cell_count_out,
   output logic                                   loaded_out,
   output logic                                   error_out,
   output logic                                   timeout_out
);

   localparam int CELLS   = GRID_SIZE * GRID_SIZE;
   localparam int BOARD_W = CELLS * CELL_W;

   typedef enum logic [1:0] {S_LOAD, S_KICK, S_WAIT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [BOARD_W-1:0] board_q, board_d;
   logic [6:0]         count_q, count_d;
   logic               error_q, error_d;
   logic [31:0]        kick_q, kick_d;
   logic               xfer;
   logic               bad_digit;
   logic [CELL_W-1:0]  digit_w;
`ifdef SOLVE_TIMEOUT_EN
   logic [31:0]        wd_q, wd_d;
   logic               timeout_q, timeout_d;
`endif

   assign xfer      = digit_valid_in && (state_q == S_LOAD);
   assign bad_digit = (digit_in > CELL_W'(9));
   assign digit_w   = bad_digit ? '0 : digit_in;

   always_comb begin
      state_d = state_q;
      board_d = board_q;
      count_d = count_q;
      error_d = error_q;
      kick_d  = kick_q;
`ifdef SOLVE_TIMEOUT_EN
      wd_d      = wd_q;
      timeout_d = timeout_q;
`endif
      if (clear_in) begin
         state_d = S_LOAD;
         board_d = '0;
         count_d = '0;
         error_d = 1'b0;
         kick_d  = '0;
`ifdef SOLVE_TIMEOUT_EN
         wd_d      = '0;
         timeout_d = 1'b0;
`endif
      end else begin
         case (state_q)
            S_LOAD: begin
               kick_d = '0;
               if (xfer) begin
                  for (int k = 0; k < CELLS; k++) begin
                     if (count_q == 7'(k))
                        board_d[BOARD_W-1-CELL_W*k -: CELL_W] = digit_w;
                  end
                  if (bad_digit)
                     error_d = 1'b1;
                  count_d = count_q + 7'd1;
                  if (count_q == 7'(CELLS-1))
                     state_d = S_KICK;
               end
            end
            S_KICK: begin
               if (kick_q == 32'(SOLVE_RST_CYCLES-1)) begin
                  state_d = S_WAIT;
`ifdef SOLVE_TIMEOUT_EN
                  wd_d    = '0;
`endif
               end else begin
                  kick_d = kick_q + 32'd1;
               end
            end
            S_WAIT: begin
               if (solver_done_in) begin
                  state_d = S_DONE;
`ifdef SOLVE_TIMEOUT_EN
               end else if (wd_q == 32'(TIMEOUT_CYCLES-1)) begin
                  state_d   = S_DONE;
                  timeout_d = 1'b1;
               end else begin
                  wd_d = wd_q + 32'd1;
`endif
               end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_LOAD;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q <= S_LOAD;
         board_q <= '0;
         count_q <= '0;
         error_q <= 1'b0;
         kick_q  <= '0;
`ifdef SOLVE_TIMEOUT_EN
         wd_q      <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         board_q <= board_d;
         count_q <= count_d;
         error_q <= error_d;
         kick_q  <= kick_d;
`ifdef SOLVE_TIMEOUT_EN
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign digit_ready_out  = (state_q == S_LOAD);
   assign solver_reset_out = (state_q == S_LOAD) || (state_q == S_KICK);
   assign loaded_out       = (state_q == S_DONE);
   assign board_out        = board_q;
   assign cell_count_out   = count_q;
   assign error_out        = error_q;
`ifdef SOLVE_TIMEOUT_EN
   assign timeout_out      = timeout_q;
`else
   assign timeout_out      = 1'b0;
`endif

endmodule

// File: tb/tb_soduku_board_loader.sv
// tb/tb_soduku_board_loader.sv - directed vector bench for soduku_board_loader.
module tb_soduku_board_loader;

   logic         clk_in = 1'b0;
   logic         reset_n_in;
   logic [3:0]   digit_in;
   logic         digit_valid_in;
   logic         digit_ready_out;
   logic         clear_in;
   logic [323:0] board_out;
   logic         solver_reset_out;
   logic         solver_done_in;
   logic [6:0]   cell_count_out;
   logic         loaded_out;
   logic         error_out;
   logic         timeout_out;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_in = ~clk_in;

   soduku_board_loader #(.TIMEOUT_CYCLES(100)) dut (
      .clk_in           (clk_in),
      .reset_n_in       (reset_n_in),
      .digit_in         (digit_in),
      .digit_valid_in   (digit_valid_in),
      .digit_ready_out  (digit_ready_out),
      .clear_in         (clear_in),
      .board_out        (board_out),
      .solver_reset_out (solver_reset_out),
      .solver_done_in   (solver_done_in),
      .cell_count_out   (cell_count_out),
      .loaded_out       (loaded_out),
      .error_out        (error_out),
      .timeout_out      (timeout_out)
   );

   typedef struct {
      logic         valid;
      logic [3:0]   digit;
      logic         clear;
      logic         done;
      logic         exp_ready;
      logic         exp_sreset;
      logic [6:0]   exp_count;
      logic         exp_loaded;
      logic         exp_error;
      logic [323:0] exp_board;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [3:0] grid(input int i);
      int          sh[9];
      logic [3:0]  row0[9];
      sh   = '{0, 3, 6, 2, 5, 8, 1, 7, 4};
      row0 = '{4'd2, 4'd5, 4'd4, 4'd8, 4'd1, 4'd3, 4'd6, 4'd9, 4'd7};
      return row0[((i % 9) + sh[i / 9]) % 9];
   endfunction

   function automatic vec_t mk(input logic v, input logic [3:0] d, input logic c,
                               input logic dn, input logic er, input logic es,
                               input int ec, input logic el, input logic ee,
                               input logic [323:0] eb);
      vec_t t;
      t.valid = v; t.digit = d; t.clear = c; t.done = dn;
      t.exp_ready = er; t.exp_sreset = es; t.exp_count = 7'(ec);
      t.exp_loaded = el; t.exp_error = ee; t.exp_board = eb;
      return t;
   endfunction

   task automatic chk(input string name, input logic [323:0] act, input logic [323:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] d, input logic c, input logic dn);
      digit_valid_in = v;
      digit_in       = d;
      clear_in       = c;
      solver_done_in = dn;
   endtask

   task automatic load_cells(input int n, input logic [3:0] first);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, (i == 0) ? first : grid(i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   logic [323:0] b;
   logic [323:0] ref_full;
   int           idx;

   initial begin
      reset_n_in = 1'b0;
      drive(1'b0, 4'd0, 1'b0, 1'b0);

      b = '0;
      for (int i = 0; i < 81; i++) begin
         if (i != 10) b[323-4*i -: 4] = grid(i);
         vecs.push_back(mk(1'b1, (i == 10) ? 4'hC : grid(i), 1'b0, 1'b0,
                           i < 80, 1'b1, i + 1, 1'b0, i >= 10, b));
      end
      vecs.push_back(mk(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 81, 1'b0, 1'b1, b));
      vecs.push_back(mk(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 81, 1'b0, 1'b1, b));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 81, 1'b0, 1'b1, b));
      vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 81, 1'b1, 1'b1, b));
      vecs.push_back(mk(1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 81, 1'b1, 1'b1, b));
      vecs.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 81, 1'b1, 1'b1, b));
      vecs.push_back(mk(1'b1, 4'd9, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, '0));
      vecs.push_back(mk(1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0,
                        {4'd7, 320'd0}));

      ref_full = '0;
      for (int i = 0; i < 81; i++) ref_full[323-4*i -: 4] = grid(i);

      #12;
      chk("rst board", board_out, '0);
      chk("rst count", 324'(cell_count_out), 324'(0));
      chk("rst sreset", 324'(solver_reset_out), 324'(1));
      chk("rst ready", 324'(digit_ready_out), 324'(1));
      chk("rst loaded", 324'(loaded_out), 324'(0));
      chk("rst error", 324'(error_out), 324'(0));
      chk("rst timeout", 324'(timeout_out), 324'(0));
      reset_n_in = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].digit, vecs[i].clear, vecs[i].done);
         tick();
         chk($sformatf("v%0d ready", i), 324'(digit_ready_out), 324'(vecs[i].exp_ready));
         chk($sformatf("v%0d sreset", i), 324'(solver_reset_out), 324'(vecs[i].exp_sreset));
         chk($sformatf("v%0d count", i), 324'(cell_count_out), 324'(vecs[i].exp_count));
         chk($sformatf("v%0d loaded", i), 324'(loaded_out), 324'(vecs[i].exp_loaded));
         chk($sformatf("v%0d error", i), 324'(error_out), 324'(vecs[i].exp_error));
         chk($sformatf("v%0d board", i), board_out, vecs[i].exp_board);
         chk($sformatf("v%0d timeout", i), 324'(timeout_out), 324'(0));
      end

      drive(1'b0, 4'd0, 1'b1, 1'b0);
      tick();
      idx = 0;
      for (int cyc = 0; cyc < 280; cyc++) begin
         logic acc;
         if (cyc % 3 == 0) drive(1'b1, (idx < 81) ? grid(idx) : 4'd7, 1'b0, 1'b0);
         else              drive(1'b0, 4'd0, 1'b0, 1'b0);
         acc = digit_valid_in && digit_ready_out;
         tick();
         if (acc) idx++;
      end
      drive(1'b0, 4'd0, 1'b0, 1'b0);
      chk("gap accepted", 324'(idx), 324'(81));
      chk("gap count", 324'(cell_count_out), 324'(81));
      chk("gap board", board_out, ref_full);
      chk("gap ready", 324'(digit_ready_out), 324'(0));
      chk("gap sreset", 324'(solver_reset_out), 324'(0));
      chk("gap loaded", 324'(loaded_out), 324'(0));
      chk("gap error", 324'(error_out), 324'(0));

      drive(1'b0, 4'd0, 1'b1, 1'b0);
      tick();
      load_cells(40, grid(0));
      chk("c40 count", 324'(cell_count_out), 324'(40));
      drive(1'b1, 4'd3, 1'b1, 1'b0);
      tick();
      drive(1'b0, 4'd0, 1'b0, 1'b0);
      chk("clr count", 324'(cell_count_out), 324'(0));
      chk("clr board", board_out, '0);
      chk("clr ready", 324'(digit_ready_out), 324'(1));

      load_cells(81, 4'hF);
      tick();
      tick();
      tick();
      chk("wait sreset", 324'(solver_reset_out), 324'(0));
      chk("wait error", 324'(error_out), 324'(1));
      #3;
      reset_n_in = 1'b0;
      #1;
      chk("arst board", board_out, '0);
      chk("arst count", 324'(cell_count_out), 324'(0));
      chk("arst sreset", 324'(solver_reset_out), 324'(1));
      chk("arst ready", 324'(digit_ready_out), 324'(1));
      chk("arst loaded", 324'(loaded_out), 324'(0));
      chk("arst error", 324'(error_out), 324'(0));
      #1;
      reset_n_in = 1'b1;
      tick();

`ifdef SOLVE_TIMEOUT_EN
      load_cells(81, grid(0));
      tick();
      tick();
      for (int i = 0; i < 99; i++) tick();
      chk("wd99 loaded", 324'(loaded_out), 324'(0));
      tick();
      chk("wd loaded", 324'(loaded_out), 324'(1));
      chk("wd timeout", 324'(timeout_out), 324'(1));
      drive(1'b0, 4'd0, 1'b1, 1'b0);
      tick();
      chk("wd clr timeout", 324'(timeout_out), 324'(0));
      load_cells(81, grid(0));
      tick();
      tick();
      for (int i = 0; i < 99; i++) tick();
      drive(1'b0, 4'd0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 4'd0, 1'b0, 1'b0);
      chk("wdd loaded", 324'(loaded_out), 324'(1));
      chk("wdd timeout", 324'(timeout_out), 324'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
